// File: rtl/verilated_stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy and traffic counters.
// Storage is an unreset array; only pointers, level and counters are cleared.
module verilated_stream_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      level,
  output logic [7:0]       push_count,
  output logic [7:0]       stall_count
);

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  generate
    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("verilated_stream_fifo: WIDTH must be >= 1 and DEPTH a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [7:0]       r_push_count;
  logic [7:0]       r_stall_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_stall;

  // Handshake readiness depends only on registered occupancy, never on out_ready.
  assign w_in_ready  = (r_level != LEVEL_FULL);
  assign w_out_valid = (r_level != '0);

  assign w_push  = in_valid && w_in_ready && !async_rst;
  assign w_pop   = w_out_valid && out_ready && !async_rst;
  assign w_stall = in_valid && !w_in_ready && !async_rst;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_push_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_push_count <= r_push_count + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign level       = r_level;
  assign push_count  = r_push_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_verilated_stream_fifo.sv
// Directed bench for verilated_stream_fifo: reset, single word, fill/stall,
// streaming wrap, mid-traffic reset and push counter wrap.
module tb_verilated_stream_fifo;

  localparam int WIDTH = 24;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             async_rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      level;
  logic [7:0]       push_count;
  logic [7:0]       stall_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  verilated_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .async_rst  (async_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .push_count (push_count),
    .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one edge with the bus idle; returns aligned just after an edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    async_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset asserted between edges must act before the next edge.
    #3;
    async_rst = 1'b1;
    #1;
    check("rst_level",  32'(level), 32'd0);
    check("rst_in_rdy", 32'(in_ready), 32'd1);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_odata",  32'(out_data), 32'd0);
    check("rst_push",   32'(push_count), 32'd0);
    check("rst_stall",  32'(stall_count), 32'd0);
    @(negedge clk);
    async_rst = 1'b0;
    step();
    $display("[TB] reset checked");

    // Single word: visible one edge after the push, then popped.
    in_valid = 1'b1;
    in_data  = 24'hA5A5A5;
    check("empty_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("single_ovalid", 32'(out_valid), 32'd1);
    check("single_odata",  32'(out_data), 32'hA5A5A5);
    check("single_level",  32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_level", 32'(level), 32'd0);
    check("single_pop_odata", 32'(out_data), 32'd0);
    $display("[TB] single word 0xa5a5a5 pushed and popped");

    // Fill to DEPTH, then three stalled cycles.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(i);
      step();
    end
    in_data = 24'h9;
    step();
    step();
    step();
    check("full_in_rdy", 32'(in_ready), 32'd0);
    check("full_level",  32'(level), 32'd8);
    check("full_push",   32'(push_count), 32'd8);
    check("full_stall",  32'(stall_count), 32'd3);
    check("full_head",   32'(out_data), 32'd1);
    // Pop while full: the concurrent push is refused and counted as a stall.
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("popfull_level", 32'(level), 32'd7);
    check("popfull_stall", 32'(stall_count), 32'd4);
    check("popfull_push",  32'(push_count), 32'd8);
    check("popfull_in_rdy", 32'(in_ready), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("drain_%0d", k), 32'(out_data), 32'(k));
      step();
    end
    out_ready = 1'b0;
    check("drain_level",  32'(level), 32'd0);
    check("drain_ovalid", 32'(out_valid), 32'd0);
    $display("[TB] fill/stall/drain done");

    // Streaming across two pointer wraps.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 24'(32'h100 + i);
      step();
      check($sformatf("stream_data_%0d", i), 32'(out_data), 32'h100 + 32'(i));
      check($sformatf("stream_level_%0d", i), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    check("stream_push", 32'(push_count), 32'd20);
    step();
    out_ready = 1'b0;
    check("stream_end_level", 32'(level), 32'd0);
    $display("[TB] streamed 20 words 0x100..0x113");

    // Reset in the middle of traffic; a push held during reset must not land.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(32'h500 + i);
      step();
    end
    check("mid_prefill_level", 32'(level), 32'd5);
    in_data   = 24'hBAD;
    #2;
    async_rst = 1'b1;
    #1;
    check("mid_rst_level",  32'(level), 32'd0);
    check("mid_rst_odata",  32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_level", 32'(level), 32'd0);
    check("mid_rst_hold_push",  32'(push_count), 32'd0);
    @(negedge clk);
    async_rst = 1'b0;
    in_valid  = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 24'h777;
    step();
    in_valid = 1'b0;
    check("mid_odata", 32'(out_data), 32'h777);
    check("mid_level", 32'(level), 32'd1);
    check("mid_push",  32'(push_count), 32'd1);
    check("mid_stall", 32'(stall_count), 32'd0);
    $display("[TB] mid-traffic reset then 0x777");

    // 257 accepted pushes with continuous drain wraps push_count to 1.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 24'(32'h1000 + i);
      step();
    end
    in_valid = 1'b0;
    check("wrap_push",  32'(push_count), 32'd1);
    check("wrap_stall", 32'(stall_count), 32'd0);
    check("wrap_data",  32'(out_data), 32'h1000 + 32'd256);
    step();
    out_ready = 1'b0;
    $display("[TB] 257 pushes, push_count wrap checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/verilated_stream_fifo.md
# verilated_stream_fifo

Synchronous valid/ready FIFO fixture for the Verilator harness. It buffers a parallel data bus, such as the 24-bit medium bus produced by the existing signal/counter fixtures, and presents it to a consumer with full handshake semantics. It gives the C++ harness a stateful target for its stream drivers and monitors: backpressure, fill/drain, pointer wrap, and asynchronous reset in the middle of traffic. It also exports occupancy and traffic counters so the harness can check internal state without peeking into the design.

## Interface
- WIDTH, default 24: data bus width in bits; must be ≥ 1.
- DEPTH, default 8: entry count; must be a power of two and ≥ 2.
- AW, derived as $clog2(DEPTH): pointer width.

- clk, in, 1: sole clock; all state updates on its rising edge.
- async_rst, in, 1: reset, asynchronous and active-high.
- in_valid, in, 1: upstream word present.
- in_ready, out, 1: FIFO can accept a word this cycle.
- in_data, in, WIDTH: upstream word.
- out_valid, out, 1: head word present.
- out_ready, in, 1: downstream takes the head word this cycle.
- out_data, out, WIDTH: head word; forced to 0 when out_valid is low.
- level, out, AW+1: current occupancy, 0..DEPTH.
- push_count, out, 8: accepted pushes, modulo 256.
- stall_count, out, 8: cycles with in_valid && !in_ready, modulo 256.

## Operation
- Push (accept): in_valid && in_ready. in_data is written to mem[wr_ptr], and wr_ptr advances.
- Pop (take): out_valid && out_ready. rd_ptr advances.
- Pointers are AW bits wide and wrap from DEPTH-1 to 0 with no special case.
- level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Unchanged when neither occurs.
- in_ready = (level != DEPTH). It is driven only from registered state, so there is no combinational path from out_ready.
- Full with a pop in the same cycle: in_ready is still low, so the push is refused and counted as a stall.
- out_valid = (level != 0). out_data = mem[rd_ptr] when out_valid, else 0. The read is combinational (first-word fall-through).
- Empty with in_valid: the word is written, but it is not bypassed to the output in the same cycle.
- Counters: push_count increments on each push and stall_count on each stall cycle. Both wrap 255 → 0.
- Reset, asserted at any time including mid-transfer, immediately forces:
  - wr_ptr, rd_ptr, level = 0
  - push_count, stall_count = 0
  - therefore in_ready = 1, out_valid = 0, out_data = 0
- Storage contents are not reset. Words in flight at reset are discarded.
- Reset deassertion is synchronised by the harness. The block performs no push or pop in any cycle in which async_rst is high.

## Timing
- Push-to-visible latency: 1 cycle. A word pushed at edge N appears on out_data with out_valid high after edge N.
- Throughput: one push and one pop per cycle sustained for 0 < level < DEPTH.
- in_ready falls after the edge that makes level = DEPTH. It rises after the first pop edge from full.
- All outputs except out_data are registered or decoded from registered state. out_data passes through a mux from storage.
- Ordering: strictly FIFO. No word is duplicated or lost without a reset.

## Test plan
- Reset: assert async_rst between clock edges. Before the next edge, expect level = 0, in_ready = 1, out_valid = 0, out_data = 0, push_count = 0, stall_count = 0.
- Single word: push 0xA5A5A5 with out_ready = 0. After 1 edge, expect out_valid = 1, out_data = 0xA5A5A5, level = 1. Pop it and expect level = 0, out_data = 0.
- Fill and stall: push 1..8 with out_ready = 0, then hold in_valid for 3 more cycles.
  - Expect in_ready = 0, level = 8, push_count = 8, stall_count = 3.
  - In the same cycle, pop while full with in_valid high: expect the push refused, level = 7, stall_count = 4.
- Streaming and wrap: run in_valid = out_ready = 1 over 20 words of values 0x100..0x113. Expect outputs in order, level steady at 1 after the first edge, and push_count = 20.
- Reset mid-operation: fill 5 words, assert async_rst for 1 cycle, then push 0x777. Expect output 0x777 first, with level = 1 and push_count = 1.
- Counter wrap: perform 257 accepted pushes with continuous drain. Expect push_count = 1.
